sevenseg_scan_decoder: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment encoder: it watches a multiplexed seven-segment bus (one-hot digit strobe plus abcdefg segment lines) and recovers the displayed digit values. Each digit is accepted only after its pattern is stable for a configurable number of cycles. Once every digit position has been captured, the block emits one packed frame on a valid/ready handshake. It sits between the display-drive nets and test or monitor logic that checks what the display shows.

---
 rtl/sevenseg_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_decoder.sv
// Recovers digit values from a multiplexed seven-segment bus and emits one packed frame per full scan.
// Optional build macro: SEVENSEG_DEC_HEX_EN additionally decodes the A..F glyphs as hex values.
module sevenseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    input  logic [6:0]              segments,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [5*NUM_DIGITS-1:0] frame_data,
    output logic                    overrun
);

    typedef enum logic {
        ACQ,
        HOLD
    } state_t;

    localparam int ACCEPT_AT = STABLE_CYCLES - 2;

    state_t                    state;
    state_t                    state_next;

    logic [NUM_DIGITS-1:0]     sel_q;
    logic [6:0]                seg_q;
    logic [3:0]                cnt;
    logic [3:0]                cnt_next;
    logic                      locked;
    logic                      locked_next;
    logic                      same_pair;
    logic                      accept;
    logic [4:0]                dec_slot;

    logic [4:0]                slots [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     seen;
    logic [NUM_DIGITS-1:0]     seen_next;
    logic [5*NUM_DIGITS-1:0]   packed_slots;

    logic                      seen_full;
    logic                      transfer;
    logic                      load_frame;
    logic                      drop_frame;

    // Slot format is {inv, val}: blank gives {1,0}, anything unrecognised gives {1,F}.
    function automatic logic [4:0] decode_segments(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
`ifdef SEVENSEG_DEC_HEX_EN
            7'b1110111: r = 5'h0A;
            7'b0011111: r = 5'h0B;
            7'b1001110: r = 5'h0C;
            7'b0111101: r = 5'h0D;
            7'b1001111: r = 5'h0E;
            7'b1000111: r = 5'h0F;
`endif
            7'b0000000: r = 5'h10;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // Stability tracking: the first sample of a new pair leaves cnt at 0, so the
    // STABLE_CYCLES-th identical sample is the one that sees cnt >= STABLE_CYCLES-2.
    always_comb begin
        same_pair   = $onehot(digit_sel) && (digit_sel == sel_q) && (segments == seg_q);
        accept      = same_pair && !locked && (int'(cnt) >= ACCEPT_AT);
        cnt_next    = 4'd0;
        if (same_pair) begin
            cnt_next = (int'(cnt) == STABLE_CYCLES) ? cnt : cnt + 4'd1;
        end
        locked_next = same_pair && (locked || accept);
        dec_slot    = decode_segments(segments);
    end

    always_comb begin
        packed_slots = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            packed_slots[5*i +: 5] = slots[i];
        end
    end

    always_comb begin
        seen_full  = &seen;
        transfer   = frame_valid && frame_ready;
        state_next = state;
        load_frame = 1'b0;
        drop_frame = 1'b0;
        case (state)
            ACQ: begin
                if (seen_full) begin
                    load_frame = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (seen_full) begin
                    load_frame = transfer;
                    drop_frame = !transfer;
                end else if (transfer) begin
                    state_next = ACQ;
                end
            end
            default: state_next = ACQ;
        endcase
        // An accept landing on the clearing edge survives in the fresh mask.
        seen_next = seen_full ? '0 : seen;
        if (accept) begin
            seen_next = seen_next | digit_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ACQ;
            sel_q  <= '0;
            seg_q  <= '0;
            cnt    <= '0;
            locked <= 1'b0;
            seen   <= '0;
        end else begin
            state  <= state_next;
            sel_q  <= digit_sel;
            seg_q  <= segments;
            cnt    <= cnt_next;
            locked <= locked_next;
            seen   <= seen_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (accept && digit_sel[i]) begin
                    slots[i] <= dec_slot;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            overrun     <= 1'b0;
        end else begin
            frame_valid <= (state_next == HOLD);
            overrun     <= drop_frame;
            if (load_frame) begin
                frame_data <= packed_slots;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Randomised and directed bench for sevenseg_scan_decoder against a scan-level reference model.
// Honours SEVENSEG_DEC_HEX_EN the same way as the design.
module tb_sevenseg_scan_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 3;

    localparam logic [6:0] DIGIT_PAT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

`ifdef SEVENSEG_DEC_HEX_EN
    localparam int NUM_GLYPHS = 16;
`else
    localparam int NUM_GLYPHS = 10;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [6:0]              segments;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [5*NUM_DIGITS-1:0] frame_data;
    logic                    overrun;

    sevenseg_scan_decoder #(
        .NUM_DIGITS   (NUM_DIGITS),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digit_sel  (digit_sel),
        .segments   (segments),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_data (frame_data),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: run length of the current pair, captured slots, pending frame.
    logic [NUM_DIGITS-1:0]   pSel;
    logic [6:0]              pSeg;
    int                      run;
    logic [NUM_DIGITS-1:0]   mSeen;
    logic [4:0]              mSlot [NUM_DIGITS];
    logic                    mValid;
    logic [5*NUM_DIGITS-1:0] mData;
    logic                    mOvr;

    int                      validRises;
    int                      ovrCount;
    logic                    lastValid;
    logic [5*NUM_DIGITS-1:0] capData;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [4:0] refDecode(input logic [6:0] s);
        for (int v = 0; v < NUM_GLYPHS; v++) begin
            if (s == DIGIT_PAT[v]) return {1'b0, 4'(v)};
        end
        if (s == 7'b0000000) return 5'h10;
        return 5'h1F;
    endfunction

    task automatic modelReset();
        pSel   = '0;
        pSeg   = '0;
        run    = 0;
        mSeen  = '0;
        mValid = 1'b0;
        mData  = '0;
        mOvr   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) mSlot[i] = '0;
        lastValid = 1'b0;
    endtask

    task automatic modelStep(input logic [NUM_DIGITS-1:0] sel, input logic [6:0] seg, input logic ready);
        bit onehot;
        bit fire;
        onehot = ($countones(sel) == 1);
        if (onehot && sel == pSel && seg == pSeg) run++;
        else run = onehot ? 1 : 0;
        pSel = sel;
        pSeg = seg;
        fire = mValid && ready;
        mOvr = 1'b0;
        if (mSeen == '1) begin
            if (!mValid || fire) begin
                for (int i = 0; i < NUM_DIGITS; i++) mData[5*i +: 5] = mSlot[i];
                mValid = 1'b1;
            end else begin
                mOvr = 1'b1;
            end
            mSeen = '0;
        end else if (fire) begin
            mValid = 1'b0;
        end
        if (run == STABLE_CYCLES) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    mSlot[i] = refDecode(seg);
                    mSeen[i] = 1'b1;
                end
            end
        end
    endtask

    // One clock of stimulus: drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic applyStimulus(input logic [NUM_DIGITS-1:0] sel, input logic [6:0] seg, input logic ready);
        digit_sel   = sel;
        segments    = seg;
        frame_ready = ready;
        @(posedge clk);
        modelStep(sel, seg, ready);
        @(negedge clk);
        checkOutput("frame_valid", 32'(frame_valid), 32'(mValid));
        checkOutput("overrun", 32'(overrun), 32'(mOvr));
        if (mValid) checkOutput("frame_data", 32'(frame_data), 32'(mData));
        if (frame_valid && !lastValid) begin
            validRises++;
            capData = frame_data;
        end
        if (overrun) ovrCount++;
        lastValid = frame_valid;
    endtask

    task automatic scanDigit(input int pos, input logic [6:0] seg, input int hold, input logic ready);
        logic [NUM_DIGITS-1:0] sel;
        sel = '0;
        sel[pos] = 1'b1;
        for (int c = 0; c < hold; c++) applyStimulus(sel, seg, ready);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(frame_valid), 32'd0);
        checkOutput("reset_data", 32'(frame_data), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rises0;
        int ovr0;
        logic [5*NUM_DIGITS-1:0] expAll;

        rst_n       = 1'b0;
        digit_sel   = '0;
        segments    = '0;
        frame_ready = 1'b0;
        validRises  = 0;
        ovrCount    = 0;
        capData     = '0;
        modelReset();
        @(negedge clk);
        doReset();

        // Clean scan of 1,2,3,4 with the consumer always ready.
        rises0 = validRises;
        ovr0   = ovrCount;
        for (int d = 0; d < 4; d++) scanDigit(d, DIGIT_PAT[d+1], 5, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkOutput("scan1_frames", 32'(validRises - rises0), 32'd1);
        checkOutput("scan1_data", 32'(capData), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
        checkOutput("scan1_overrun", 32'(ovrCount - ovr0), 32'd0);

        // A digit shown for only two samples is never accepted, so no frame appears.
        rises0 = validRises;
        scanDigit(0, DIGIT_PAT[7], 2, 1'b1);
        for (int d = 1; d < 4; d++) scanDigit(d, DIGIT_PAT[d+1], 5, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus('0, '0, 1'b1);
        checkOutput("short_hold_frames", 32'(validRises - rises0), 32'd0);

        // Blank and garbage patterns.
        doReset();
        rises0 = validRises;
        scanDigit(0, 7'b0000000, 5, 1'b1);
        scanDigit(1, 7'b1010101, 5, 1'b1);
        scanDigit(2, DIGIT_PAT[8], 5, 1'b1);
        scanDigit(3, DIGIT_PAT[8], 5, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkOutput("blank_inv_frames", 32'(validRises - rises0), 32'd1);
        checkOutput("blank_inv_data", 32'(capData), 32'({5'h08, 5'h08, 5'h1F, 5'h10}));

        // Consumer stalled across two scans: first frame held, second dropped once.
        doReset();
        rises0 = validRises;
        ovr0   = ovrCount;
        for (int d = 0; d < 4; d++) scanDigit(d, DIGIT_PAT[d+1], 5, 1'b0);
        for (int d = 0; d < 4; d++) scanDigit(d, DIGIT_PAT[d+5], 5, 1'b0);
        applyStimulus('0, '0, 1'b0);
        checkOutput("stall_overrun", 32'(ovrCount - ovr0), 32'd1);
        checkOutput("stall_held_data", 32'(frame_data), 32'({5'd4, 5'd3, 5'd2, 5'd1}));
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkOutput("stall_frames", 32'(validRises - rises0), 32'd1);
        checkOutput("stall_after_xfer", 32'(frame_valid), 32'd0);

        // Reset in the middle of a scan, then a fresh scan.
        scanDigit(0, DIGIT_PAT[9], 5, 1'b1);
        scanDigit(1, DIGIT_PAT[9], 5, 1'b1);
        scanDigit(2, DIGIT_PAT[9], 2, 1'b1);
        doReset();
        rises0 = validRises;
        for (int d = 0; d < 4; d++) scanDigit(d, DIGIT_PAT[d+5], 5, 1'b1);
        for (int c = 0; c < 3; c++) applyStimulus('0, '0, 1'b1);
        checkOutput("post_reset_frames", 32'(validRises - rises0), 32'd1);
        checkOutput("post_reset_data", 32'(capData), 32'({5'd8, 5'd7, 5'd6, 5'd5}));

        // The 'A' glyph on every position.
        doReset();
`ifdef SEVENSEG_DEC_HEX_EN
        expAll = {4{5'h0A}};
`else
        expAll = {4{5'h1F}};
`endif
        for (int d = 0; d < 4; d++) scanDigit(d, 7'b1110111, 5, 1'b1);
        applyStimulus('0, '0, 1'b1);
        checkOutput("hex_a_data", 32'(capData), 32'(expAll));

        // Randomised scanning: mixed glyphs, garbage, bad strobes, random hold and back-pressure.
        for (int n = 0; n < 400; n++) begin
            logic [NUM_DIGITS-1:0] sel;
            logic [6:0]            seg;
            int                    hold;
            int                    kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 8) begin
                sel = '0;
                sel[$urandom_range(0, NUM_DIGITS-1)] = 1'b1;
            end else begin
                sel = NUM_DIGITS'($urandom);
            end
            kind = int'($urandom_range(0, 9));
            if (kind < 7)       seg = DIGIT_PAT[$urandom_range(0, 15)];
            else if (kind == 7) seg = 7'b0000000;
            else                seg = 7'($urandom);
            hold = int'($urandom_range(1, 6));
            for (int c = 0; c < hold; c++) applyStimulus(sel, seg, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) doReset();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
